mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports and the shared memory port
// of mem_arbiter.
//   m0_* : master 0 (instruction side) request, write line, read line, ack
//   m1_* : master 1 (data cache), same shape as m0_*
//   mem_*: shared data-memory request (enable/write/addr/data) and response
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
  logic         m0_enable_i;
  logic         m0_write_i;
  logic [31:0]  m0_addr_i;
  logic [255:0] m0_data_i;
  logic [255:0] m0_data_o;
  logic         m0_ack_o;

  logic         m1_enable_i;
  logic         m1_write_i;
  logic [31:0]  m1_addr_i;
  logic [255:0] m1_data_i;
  logic [255:0] m1_data_o;
  logic         m1_ack_o;

  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport slave (
    input  m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
    output m0_data_o, m0_ack_o,
    input  m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
    output m1_data_o, m1_ack_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport master (
    output m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
    input  m0_data_o, m0_ack_o,
    output m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
    input  m1_data_o, m1_ack_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of a single data memory.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   bus     : mem_arbiter_if.slave (both requesters + shared memory port)
//   grant_o : one-hot current owner ([0] = master 0)
//   busy_o  : state is not IDLE
//   err_o   : one-cycle pulse when a grant times out without mem_ack_i
// Parameters: FIXED_PRIO (0 = round-robin, 1 = master 0 always wins),
//             TIMEOUT (max grant cycles without ack, 0 = disabled).
//
// state | meaning
// IDLE  | no owner, arbitrate the sampled enables
// BUSY0 | master 0 owns the memory port
// BUSY1 | master 1 owns the memory port
// DRAIN | one dead cycle after every grant, port forced quiet
module mem_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_arbiter_if.slave      bus,
  output logic [1:0]        grant_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, DRAIN} state_t;

  state_t      state_q;
  logic        last_q;   // 1 = master 1 won last, so master 0 wins the next tie
  logic [15:0] cnt_q;
  logic        in_busy;
  logic        sel1;
  logic        owner_en;
  logic        timeout_hit;

  assign in_busy  = (state_q == BUSY0) || (state_q == BUSY1);
  assign sel1     = (state_q == BUSY1);
  assign owner_en = sel1 ? bus.m1_enable_i : bus.m0_enable_i;

  generate
    if (TIMEOUT != 0) begin : g_timeout
      assign timeout_hit = in_busy && !bus.mem_ack_i && (cnt_q == 16'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Holding the counter at zero here gives the clear-on-entry.
          cnt_q <= '0;
          if (bus.m0_enable_i && bus.m1_enable_i)
            state_q <= ((FIXED_PRIO != 0) || last_q) ? BUSY0 : BUSY1;
          else if (bus.m0_enable_i)
            state_q <= BUSY0;
          else if (bus.m1_enable_i)
            state_q <= BUSY1;
        end
        BUSY0, BUSY1: begin
          if (bus.mem_ack_i) begin
            state_q <= DRAIN;
            last_q  <= sel1;
          end else if (timeout_hit || !owner_en) begin
            state_q <= DRAIN;
          end
          if (cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
        end
        DRAIN:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Port muxing is decoded from the registered state so reset quiets it at once.
  always_comb begin
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_data_o   = '0;
    bus.m0_ack_o     = 1'b0;
    bus.m1_ack_o     = 1'b0;
    grant_o          = 2'b00;
    case (state_q)
      BUSY0: begin
        bus.mem_enable_o = bus.m0_enable_i;
        bus.mem_write_o  = bus.m0_write_i;
        bus.mem_addr_o   = bus.m0_addr_i;
        bus.mem_data_o   = bus.m0_data_i;
        bus.m0_ack_o     = bus.mem_ack_i;
        grant_o          = 2'b01;
      end
      BUSY1: begin
        bus.mem_enable_o = bus.m1_enable_i;
        bus.mem_write_o  = bus.m1_write_i;
        bus.mem_addr_o   = bus.m1_addr_i;
        bus.mem_data_o   = bus.m1_data_i;
        bus.m1_ack_o     = bus.mem_ack_i;
        grant_o          = 2'b10;
      end
      default: ;
    endcase
  end

  // Read data is shared; only the ack tells a master the line is for it.
  assign bus.m0_data_o = bus.mem_data_i;
  assign bus.m1_data_o = bus.mem_data_i;
  assign busy_o        = (state_q != IDLE);
  assign err_o         = timeout_hit;

endmodule
